egress_pkt_buffer: RTL
======================

// Module: egress_pkt_buffer
// PURPOSE
//  Per-port store-and-forward egress buffer. Sits directly downstream of one unpacker output
//  slice (o_val/o_sop/o_eop/o_vbc/o_data, 32-byte beats). The input has no backpressure.
//  Buffers whole packets; only complete, well-formed packets become visible downstream.
//  Drops malformed or overflowing packets. Re-emits packets on a valid/ready interface.
// PARAMETERS
//  DEPTH_P   16   beat entries; power of 2, >=2
//  DATA_W_P  256  beat data width (32 bytes)
//  VBC_W_P   8    valid-byte-count width
//  CNT_W_P   16   statistics counter width
// PORTS
//  clk        in   1         clock
//  reset_L    in   1         reset; asynchronous, active-low
//  in_val     in   1         beat valid; no backpressure
//  in_sop     in   1         first beat of packet
//  in_eop     in   1         last beat of packet
//  in_vbc     in   VBC_W_P   valid bytes in beat; legal range 1..32
//  in_data    in   DATA_W_P  beat data
//  out_val    out  1         output beat valid
//  out_sop    out  1         output first beat
//  out_eop    out  1         output last beat
//  out_vbc    out  VBC_W_P   output valid bytes
//  out_data   out  DATA_W_P  output beat data
//  out_rdy    in   1         downstream accepts beat when out_val&out_rdy
//  empty      out  1         no committed beats pending
//  pkt_cnt    out  CNT_W_P   packets committed; saturating
//  drop_cnt   out  CNT_W_P   packets or stray beats dropped; saturating
// BEHAVIOUR
//  - Storage: DEPTH_P entries of {sop,eop,vbc,data}.
//  - Pointers are log2(DEPTH_P)+1 bits wide, with a wrap bit: wr_ptr, commit_ptr, rd_ptr.
//  - occ = wr_ptr - rd_ptr. This count includes uncommitted beats.
//  - Reset (async): all pointers 0, FSM IDLE, counters 0. Outputs: out_val=0, out_sop=0,
//    out_eop=0, out_vbc=0, empty=1. out_data is don't-care while out_val=0.
//  - Ingress FSM. Beat is "bad" if in_vbc==0 or in_vbc>32, or if occ==DEPTH_P.
//    The occ check uses the value before this cycle's pop. A same-cycle pop does not save the beat.
//    IDLE:
//      in_val&in_sop&!bad -> write beat. If in_eop, commit; else go to PKT.
//      in_val&in_sop&bad  -> drop_cnt++. Go to DROP unless in_eop, else stay IDLE.
//      in_val&!in_sop     -> stray beat: discard, drop_cnt++, stay IDLE.
//    PKT:
//      in_val&!in_sop&!bad -> write beat. If in_eop, commit and go to IDLE.
//      in_val&!in_sop&bad  -> wr_ptr<=commit_ptr (rollback), drop_cnt++.
//                             Go to DROP, or IDLE if in_eop.
//      in_val&in_sop       -> missing eop: roll back, drop_cnt++.
//                             Then process the beat exactly as in IDLE, same cycle.
//                             That beat lands at the rolled-back address.
//    DROP:
//      discard all beats; in_eop -> IDLE.
//      in_sop while in DROP -> process as in IDLE (new packet starts).
//  - Commit: commit_ptr <= wr_ptr+1 on the eop write; pkt_cnt++.
//    Committed beats are visible on out_* the cycle after the eop write.
//    Minimum latency for a single-beat packet: in at cycle N, out_val at N+1.
//  - Egress:
//      out_val = (rd_ptr != commit_ptr). out_* come from entry rd_ptr.
//      On out_val&out_rdy, rd_ptr++.
//      out_* must hold stable while out_val&!out_rdy.
//      empty = !out_val.
//  - A pop and a write/commit in the same cycle are legal. Pointers wrap modulo 2*DEPTH_P.
//  - A packet longer than DEPTH_P beats always overflows and is dropped.
//  - Counters saturate at all-ones. Data is never reordered. Beats are never duplicated.
//  - Reset mid-packet discards all buffered and partial data.
// TESTING
//  1. 1-beat pkt (sop,eop,vbc=20,data=A) at cyc 5, out_rdy=1
//     -> out_val, sop, eop, vbc=20, data=A at cyc 6; pkt_cnt=1.
//  2. 4-beat pkt, out_rdy=0 for 10 cycles
//     -> out_val holds beat0 stable; release -> 4 beats in order, eop on 4th; empty=1 after.
//  3. 3 beats sop,-,- then a new 2-beat packet with sop
//     -> first packet dropped (drop_cnt=1); only the 2-beat packet is output.
//  4. DEPTH_P=16, out_rdy=0, 20-beat packet
//     -> overflow at beat 17; drop_cnt=1, pkt_cnt=0, empty=1; next 1-beat pkt is accepted.
//  5. Stray beat (no sop) in IDLE, plus a sop beat with vbc=0
//     -> both discarded; drop_cnt=2; nothing is output.
//  6. Random back-to-back pkts of 1..8 beats, random out_rdy, 1000 pkts
//     -> scoreboard shows exact in-order match; pointer wrap is exercised.
//     Also: assert reset_L mid-packet -> outputs are at reset values immediately (async reset).

Source files
------------

// File: rtl/egress_pkt_buffer.sv
// egress_pkt_buffer: per-port store-and-forward egress buffer.
// Beats are written speculatively at wr_ptr. They become visible downstream only
// once the packet's eop beat is written, which moves commit_ptr. A malformed,
// truncated or overflowing packet is dropped by rolling wr_ptr back to commit_ptr.
//
// Egress handshake: a beat transfers on a cycle where out_val and out_rdy are both
// high at the rising clock edge. out_val never depends on out_rdy. While out_val is
// high and out_rdy is low, every out_* field holds its value.
module egress_pkt_buffer #(
  parameter int DEPTH_P  = 16,
  parameter int DATA_W_P = 256,
  parameter int VBC_W_P  = 8,
  parameter int CNT_W_P  = 16
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                in_val,
  input  logic                in_sop,
  input  logic                in_eop,
  input  logic [VBC_W_P-1:0]  in_vbc,
  input  logic [DATA_W_P-1:0] in_data,
  output logic                out_val,
  output logic                out_sop,
  output logic                out_eop,
  output logic [VBC_W_P-1:0]  out_vbc,
  output logic [DATA_W_P-1:0] out_data,
  input  logic                out_rdy,
  output logic                empty,
  output logic [CNT_W_P-1:0]  pkt_cnt,
  output logic [CNT_W_P-1:0]  drop_cnt,
  output logic [1:0]          state_dbg
);

  localparam int AW = $clog2(DEPTH_P);
  localparam int PW = AW + 1;
  localparam logic [VBC_W_P-1:0] BEAT_BYTES = VBC_W_P'(DATA_W_P / 8);
  localparam logic [PW-1:0]      FULL_OCC   = PW'(DEPTH_P);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t state;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;

  logic                sop_mem  [DEPTH_P];
  logic                eop_mem  [DEPTH_P];
  logic [VBC_W_P-1:0]  vbc_mem  [DEPTH_P];
  logic [DATA_W_P-1:0] data_mem [DEPTH_P];

  logic          restart;
  logic          start;
  logic          cont;
  logic          stray;
  logic          vbc_bad;
  logic          bad;
  logic          wr_en;
  logic          commit;
  logic          rollback;
  logic          pop;
  logic [PW-1:0] base;
  logic [PW-1:0] occ;
  logic [1:0]    drop_add;
  state_t        next_after_beat;
  logic [CNT_W_P:0] pkt_sum;
  logic [CNT_W_P:0] drop_sum;
  logic [AW-1:0] rd_idx;

  // Decode this cycle's ingress action. A sop arriving in PKT abandons the open
  // packet first, so the new beat is judged and written from commit_ptr.
  always_comb begin
    restart  = (state == S_PKT) && in_val && in_sop;
    base     = restart ? commit_ptr : wr_ptr;
    occ      = base - rd_ptr;
    vbc_bad  = (in_vbc == '0) || (in_vbc > BEAT_BYTES);
    bad      = vbc_bad || (occ == FULL_OCC);
    start    = in_val && in_sop;
    cont     = in_val && !in_sop && (state == S_PKT);
    stray    = in_val && !in_sop && (state == S_IDLE);
    wr_en    = (start || cont) && !bad;
    commit   = wr_en && in_eop;
    rollback = restart || (cont && bad);
    drop_add = {1'b0, restart} + {1'b0, (start || cont) && bad} + {1'b0, stray};
    if (in_eop) begin
      next_after_beat = S_IDLE;
    end else if (bad) begin
      next_after_beat = S_DROP;
    end else begin
      next_after_beat = S_PKT;
    end
    pkt_sum  = {1'b0, pkt_cnt} + (CNT_W_P + 1)'(commit);
    drop_sum = {1'b0, drop_cnt} + (CNT_W_P + 1)'(drop_add);
  end

  // Egress view: the head entry is presented whenever committed beats are pending.
  always_comb begin
    rd_idx   = rd_ptr[AW-1:0];
    out_val  = (rd_ptr != commit_ptr);
    out_sop  = out_val && sop_mem[rd_idx];
    out_eop  = out_val && eop_mem[rd_idx];
    out_vbc  = out_val ? vbc_mem[rd_idx] : '0;
    out_data = data_mem[rd_idx];
    empty    = !out_val;
    pop      = out_val && out_rdy;
    state_dbg = state;
  end

  // Beat storage; an entry is never rewritten while it is still unread because
  // the occupancy check counts from rd_ptr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      sop_mem[base[AW-1:0]]  <= in_sop;
      eop_mem[base[AW-1:0]]  <= in_eop;
      vbc_mem[base[AW-1:0]]  <= in_vbc;
      data_mem[base[AW-1:0]] <= in_data;
    end
  end

  // Ingress FSM together with pointers and saturating statistics.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= base + 1'b1;
      end else if (rollback) begin
        wr_ptr <= commit_ptr;
      end
      if (commit) begin
        commit_ptr <= base + 1'b1;
      end
      pkt_cnt  <= pkt_sum[CNT_W_P]  ? '1 : pkt_sum[CNT_W_P-1:0];
      drop_cnt <= drop_sum[CNT_W_P] ? '1 : drop_sum[CNT_W_P-1:0];
      case (state)
        S_IDLE: begin
          if (start) state <= next_after_beat;
        end
        S_PKT: begin
          if (start || cont) state <= next_after_beat;
        end
        S_DROP: begin
          if (start) begin
            state <= next_after_beat;
          end else if (in_val && in_eop) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
